// File: rtl/decoder.sv
// Manchester line decoder for the Ethernet receive path.
//
// Registers one half-bit sample per Sample strobe, emits one NRZ bit per Shift_Enable
// strobe and flags an idle line when three or more consecutive samples are equal.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   n_rst        synchronous active-low reset
//   Sync_Ether   synchronized Manchester line level
//   Sample       one-cycle strobe: capture Sync_Ether as the next half-bit
//   Shift_Enable one-cycle strobe: emit the decoded bit for the current bit cell
//   e_orig       decoded data bit (registered)
//   Idle         no transition for 3 or more consecutive samples
//
// Configuration macro:
//   DECODER_THOMAS_EN  defined: G.E. Thomas polarity (bit 0 = low then high)
//                      undefined: IEEE 802.3 polarity (bit 0 = high then low)

module decoder (
  input  logic clk,
  input  logic n_rst,
  input  logic Sync_Ether,
  input  logic Sample,
  input  logic Shift_Enable,
  output logic e_orig,
  output logic Idle
);

  logic       s_cur_q, s_cur_d;
  logic [1:0] run_q, run_d;
  logic       e_orig_q, e_orig_d;
  logic       first_half;

  // With both strobes in one cycle the incoming sample is the first half of the cell.
  always_comb begin
    first_half = Sample ? Sync_Ether : s_cur_q;
  end

  always_comb begin
    s_cur_d  = s_cur_q;
    run_d    = run_q;
    e_orig_d = e_orig_q;
    if (Sample) begin
      s_cur_d = Sync_Ether;
      if (Sync_Ether != s_cur_q) begin
        run_d = 2'd1;
      end else if (run_q != 2'd3) begin
        run_d = run_q + 2'd1;
      end
    end
    if (Shift_Enable) begin
`ifdef DECODER_THOMAS_EN
      e_orig_d = first_half;
`else
      e_orig_d = ~first_half;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s_cur_q  <= 1'b0;
      run_q    <= 2'd3;
      e_orig_q <= 1'b0;
    end else begin
      s_cur_q  <= s_cur_d;
      run_q    <= run_d;
      e_orig_q <= e_orig_d;
    end
  end

  assign e_orig = e_orig_q;
  assign Idle   = (run_q == 2'd3);

endmodule

// File: tb/tb_decoder.sv
module tb_decoder;

  logic clk;
  logic n_rst;
  logic Sync_Ether;
  logic Sample;
  logic Shift_Enable;
  logic e_orig;
  logic Idle;

  int n_cmp;
  int n_err;

`ifdef DECODER_THOMAS_EN
  localparam logic Inv = 1'b0;
`else
  localparam logic Inv = 1'b1;
`endif

  decoder u_dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .Sync_Ether  (Sync_Ether),
    .Sample      (Sample),
    .Shift_Enable(Shift_Enable),
    .e_orig      (e_orig),
    .Idle        (Idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected decoded bit given the first-half line level.
  function automatic logic ebit(input logic first);
    return first ^ Inv;
  endfunction

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of strobes; outputs are stable at the following negedge.
  task automatic strobe(input logic smp, input logic sh, input logic d);
    @(negedge clk);
    Sample       = smp;
    Shift_Enable = sh;
    Sync_Ether   = d;
    @(negedge clk);
    Sample       = 1'b0;
    Shift_Enable = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // Send one byte LSB first, IEEE halves (bit 1 = 0 then 1), shift after first half.
  task automatic send_byte(input string name, input logic [7:0] data, input logic idle_first);
    logic b;
    logic first;
    for (int i = 0; i < 8; i++) begin
      b     = data[i];
      first = ~b;
      strobe(1'b1, 1'b0, first);
      check_eq($sformatf("%s bit%0d idle_h1", name, i), Idle, (i == 0) ? idle_first : 1'b0);
      strobe(1'b0, 1'b1, 1'b0);
      check_eq($sformatf("%s bit%0d e_orig", name, i), e_orig, ebit(first));
      strobe(1'b1, 1'b0, b);
      check_eq($sformatf("%s bit%0d idle_h2", name, i), Idle, 1'b0);
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    n_rst        = 1'b0;
    Sync_Ether   = 1'b0;
    Sample       = 1'b0;
    Shift_Enable = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    // Put a non-reset value on e_orig, then reset mid-bit with strobes toggling.
    strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b0, 1'b1, 1'b0);
    check_eq("pre_reset e_orig", e_orig, ebit(1'b0));
    strobe(1'b1, 1'b0, 1'b1);
    check_eq("pre_reset idle", Idle, 1'b0);
    @(negedge clk);
    n_rst = 1'b0; Sample = 1'b1; Shift_Enable = 1'b1; Sync_Ether = 1'b0;
    @(negedge clk);
    Sample = 1'b0; Shift_Enable = 1'b1; Sync_Ether = 1'b1;
    @(negedge clk);
    Sample = 1'b0; Shift_Enable = 1'b0;
    check_eq("reset e_orig", e_orig, 1'b0);
    check_eq("reset idle", Idle, 1'b1);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_reset e_orig", e_orig, 1'b0);
    check_eq("post_reset idle", Idle, 1'b1);

    // 0x00: first sample 1 differs from reset s_cur, so Idle drops immediately.
    send_byte("b00", 8'h00, 1'b0);
    do_reset();
    // 0xFF: first sample 0 matches reset s_cur, so Idle stays 1 for one sample.
    send_byte("bff", 8'hFF, 1'b1);
    // 0x55 continues from the 0xFF traffic (last half 1), so no idle window.
    send_byte("b55", 8'h55, 1'b0);

    // Idle detection: line last sampled 0; hold 1 for three samples.
    strobe(1'b1, 1'b0, 1'b1);
    check_eq("idle run1", Idle, 1'b0);
    strobe(1'b1, 1'b0, 1'b1);
    check_eq("idle run2", Idle, 1'b0);
    strobe(1'b1, 1'b0, 1'b1);
    check_eq("idle run3", Idle, 1'b1);
    strobe(1'b1, 1'b0, 1'b1);
    check_eq("idle run4 sat", Idle, 1'b1);
    strobe(1'b1, 1'b0, 1'b0);
    check_eq("idle clear", Idle, 1'b0);

    // Simultaneous strobes bypass the stored sample: s_cur=1, Sync_Ether=0.
    strobe(1'b1, 1'b0, 1'b1);
    strobe(1'b1, 1'b1, 1'b0);
    check_eq("bypass e_orig", e_orig, ebit(1'b0));
    check_eq("bypass idle", Idle, 1'b0);
    // s_cur must now be 0; a plain shift reveals it.
    strobe(1'b0, 1'b1, 1'b1);
    check_eq("bypass s_cur", e_orig, ebit(1'b0));
    // Hold with no strobes.
    repeat (3) @(negedge clk);
    check_eq("hold e_orig", e_orig, ebit(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
